// File: rtl/vtc_mode_if.sv
// Host-side mode request handshake for the VTC mode controller.
// The host drives the request; the controller answers with ready and the completion pulses.
interface vtc_mode_if;
    logic       mode_req_valid;
    logic [1:0] mode_req_sel;
    logic       mode_req_ready;
    logic       mode_done;
    logic       mode_rej;

    modport master (
        output mode_req_valid,
        output mode_req_sel,
        input  mode_req_ready,
        input  mode_done,
        input  mode_rej
    );

    modport slave (
        input  mode_req_valid,
        input  mode_req_sel,
        output mode_req_ready,
        output mode_done,
        output mode_rej
    );
endinterface

// File: rtl/vtc_mode_ctrl.sv
// Resolution-change sequencer for the video timing controller: holds the four-mode
// timing table and applies a requested mode only at a vSync falling edge (or after a timeout).
module vtc_mode_ctrl #(
    parameter logic [1:0]  DEFAULT_MODE   = 2'd0,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [3:0]  MODE_MASK      = 4'b1111
) (
    input  logic        clock_in,
    input  logic        reset,
    vtc_mode_if.slave   host,
    input  logic        vSync,
    output logic        vtc_reset_n,
    output logic [11:0] sync_time_h,
    output logic [11:0] pulse_w_h,
    output logic [11:0] bporch_h,
    output logic [11:0] fporch_h,
    output logic [11:0] sync_time_v,
    output logic [11:0] pulse_w_v,
    output logic [11:0] bporch_v,
    output logic [11:0] fporch_v,
    output logic [1:0]  cur_mode,
    output logic        err_timeout
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef struct packed {
        logic [11:0] sth;
        logic [11:0] pwh;
        logic [11:0] bph;
        logic [11:0] fph;
        logic [11:0] stv;
        logic [11:0] pwv;
        logic [11:0] bpv;
        logic [11:0] fpv;
    } timing_t;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_WAIT_VS
    } state_t;

    // Sync totals are stored as total-1 so the VTC counters wrap on that value.
    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd0:    t = '{12'd799,  12'd96,  12'd48,  12'd16,  12'd524, 12'd2, 12'd33, 12'd10};
            2'd1:    t = '{12'd1055, 12'd128, 12'd88,  12'd40,  12'd627, 12'd4, 12'd23, 12'd1};
            2'd2:    t = '{12'd1343, 12'd136, 12'd160, 12'd24,  12'd805, 12'd6, 12'd29, 12'd3};
            default: t = '{12'd1649, 12'd40,  12'd220, 12'd110, 12'd749, 12'd5, 12'd20, 12'd5};
        endcase
        return t;
    endfunction

    state_t          state;
    timing_t         prm;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   timeout_cnt;
    logic [1:0]      pending;
    logic            vs_d;
    logic            from_req;
    logic            vs_fall_c;

    assign vs_fall_c = vs_d & ~vSync;

    assign sync_time_h = prm.sth;
    assign pulse_w_h   = prm.pwh;
    assign bporch_h    = prm.bph;
    assign fporch_h    = prm.fph;
    assign sync_time_v = prm.stv;
    assign pulse_w_v   = prm.pwv;
    assign bporch_v    = prm.bpv;
    assign fporch_v    = prm.fpv;

    // Mode sequencer; from_req keeps mode_done quiet on the hold that follows reset.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state               <= S_HOLD;
            hold_cnt            <= '0;
            timeout_cnt         <= '0;
            pending             <= '0;
            vs_d                <= 1'b1;
            from_req            <= 1'b0;
            vtc_reset_n         <= 1'b0;
            cur_mode            <= DEFAULT_MODE;
            prm                 <= mode_timing(DEFAULT_MODE);
            err_timeout         <= 1'b0;
            host.mode_req_ready <= 1'b0;
            host.mode_done      <= 1'b0;
            host.mode_rej       <= 1'b0;
        end else begin
            vs_d           <= vSync;
            host.mode_done <= 1'b0;
            host.mode_rej  <= 1'b0;
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state               <= S_RUN;
                        vtc_reset_n         <= 1'b1;
                        host.mode_req_ready <= 1'b1;
                        host.mode_done      <= from_req;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    if (host.mode_req_valid && host.mode_req_ready) begin
                        if (!MODE_MASK[host.mode_req_sel]) begin
                            host.mode_rej <= 1'b1;
                        end else if (host.mode_req_sel == cur_mode) begin
                            host.mode_done <= 1'b1;
                        end else begin
                            pending             <= host.mode_req_sel;
                            timeout_cnt         <= '0;
                            host.mode_req_ready <= 1'b0;
                            state               <= S_WAIT_VS;
                        end
                    end
                end
                S_WAIT_VS: begin
                    // A real frame edge takes priority over the timeout in the same cycle.
                    if (vs_fall_c || (timeout_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
                        if (!vs_fall_c) begin
                            err_timeout <= 1'b1;
                        end
                        cur_mode    <= pending;
                        prm         <= mode_timing(pending);
                        vtc_reset_n <= 1'b0;
                        hold_cnt    <= '0;
                        from_req    <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

endmodule
